dcache_wb_dm: RTL and testbench
===============================

Name: dcache_wb_dm

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Sits directly downstream of the CPU memory-access stage. Consumes DMEM_ADDR/DATA_WRITE/READ/WRITE; returns load data already sized and extended, plus BUSYWAIT to stall the pipeline.
- Refills and evicts 16-byte blocks over a 128-bit main-memory port with its own busywait handshake.

Parameters:
- INDEX_BITS, 3, number of index bits; the cache has 2^INDEX_BITS lines. Offset is fixed at 4 bits (16 B block); tag width is 28-INDEX_BITS.

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset, asynchronous, active-low
- ADDR  in  32  byte address from the memory-access stage
- WDATA  in  32  store data (low bytes are used for SB/SH)
- READ  in  4  [3]=load enable; [2:0]=funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- WRITE  in  3  [2]=store enable; [1:0]=size (00 byte, 01 half, 10 word)
- RDATA  out  32  extended load result
- BUSYWAIT  out  1  stall request to the CPU
- MEM_READ  out  1  block read request
- MEM_WRITE  out  1  block write request
- MEM_ADDR  out  28  block address (byte address >> 4)
- MEM_WDATA  out  128  evicted block
- MEM_RDATA  in  128  refill block
- MEM_BUSYWAIT  in  1  main memory busy

Behaviour:
- Address split: tag=ADDR[31:4+INDEX_BITS], index=ADDR[3+INDEX_BITS:4], word=ADDR[3:2], byte=ADDR[1:0].
- Misaligned accesses: half-word ignores ADDR[0]; word ignores ADDR[1:0].
- Request = READ[3] | WRITE[2]. If both are set, the access is treated as a store and RDATA=0.
- Hit = valid[index] & (tag_array[index]==tag).
- Reset (RST low, asynchronous):
  - all valid and dirty bits cleared; FSM to IDLE
  - MEM_READ=MEM_WRITE=0, BUSYWAIT=0, RDATA=0
  - data and tag arrays are not cleared
  - reset mid-refill or mid-writeback abandons the transfer; no line is updated.
- FSM states and transitions:
  - IDLE:
    - no request: BUSYWAIT=0.
    - request and hit: BUSYWAIT=0 combinationally, zero-cycle latency. Load: RDATA is combinational. Store: bytes are written and dirty=1 on the next rising edge.
    - request and miss: BUSYWAIT=1 in the same cycle. Go to WRITEBACK if dirty[index], else FETCH.
  - WRITEBACK:
    - drive MEM_WRITE=1, MEM_ADDR={old tag,index}, MEM_WDATA=the line.
    - on an edge with MEM_BUSYWAIT=0, go to FETCH.
  - FETCH:
    - drive MEM_READ=1, MEM_ADDR={tag,index}.
    - on an edge with MEM_BUSYWAIT=0, capture MEM_RDATA and go to UPDATE.
  - UPDATE (one cycle): write the block and tag; valid=1, dirty=0; go to IDLE. The retried access then hits and BUSYWAIT falls.
  - BUSYWAIT=1 in WRITEBACK, FETCH and UPDATE.
- Main-memory handshake:
  - the request is held steady until completion on a rising edge where the request is high and MEM_BUSYWAIT=0.
  - memory must hold MEM_BUSYWAIT high while it is not ready.
  - the request is deasserted in the following state.
- CPU contract: ADDR, WDATA, READ and WRITE are held stable while BUSYWAIT=1.
- Load extension:
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - RDATA=0 when there is no load, or on a miss.
- Store merge: SB writes one byte lane and SH two byte lanes (selected by ADDR[1:0]); SW writes all four. Other bytes are unchanged.
- Stores never write to memory directly; eviction only.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - adds outputs HIT_COUNT[31:0] and MISS_COUNT[31:0].
  - HIT_COUNT increments once per access that completes in IDLE with no prior miss for that access.
  - MISS_COUNT increments once per IDLE-to-miss transition.
  - both wrap modulo 2^32 and are cleared by RST.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Cold LW 0x00000040 with memory block 0x4 = {w3..w0}: BUSYWAIT=1 → FETCH, MEM_ADDR=0x0000004. After fill, RDATA=w0 and BUSYWAIT=0. No MEM_WRITE.
- After SW 0xDEADBEEF to 0x44 (hit, BUSYWAIT stays 0), LB 0x47 returns 0xFFFFFFDE, LBU 0x47 returns 0x000000DE, LH 0x46 returns 0xFFFFDEAD.
- Dirty conflict (INDEX_BITS=3): LW 0xC4 evicts line 4. Expect MEM_WRITE first with MEM_ADDR=0x0000004 and MEM_WDATA[63:32]=0xDEADBEEF, then MEM_READ with MEM_ADDR=0x000000C.
- MEM_BUSYWAIT held high for 5 cycles in FETCH: MEM_READ is stable for all 5 cycles and CPU BUSYWAIT stays 1 throughout.
- RST pulsed low during FETCH: MEM_READ=0 and BUSYWAIT=0 immediately. The subsequent access to the same address misses again.
- DCACHE_STATS_EN: sequence miss, hit, hit, miss → HIT_COUNT=2, MISS_COUNT=2.

Source files
------------

// File: rtl/dcache_wb_dm.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte blocks.
// Hits are served with zero added latency; misses stall the CPU while the
// line is optionally written back and then refilled over a 128-bit port.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_wb_dm #(
  parameter int INDEX_BITS = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [31:0]   ADDR,
  input  logic [31:0]   WDATA,
  input  logic [3:0]    READ,
  input  logic [2:0]    WRITE,
  output logic [31:0]   RDATA,
  output logic          BUSYWAIT,
  output logic          MEM_READ,
  output logic          MEM_WRITE,
  output logic [27:0]   MEM_ADDR,
  output logic [127:0]  MEM_WDATA,
  input  logic [127:0]  MEM_RDATA,
  input  logic          MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]   HIT_COUNT,
  output logic [31:0]   MISS_COUNT
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_FETCH,
    S_UPDATE
  } state_t;

  state_t state_reg, state_next;

  // Line storage; data and tags are deliberately left unreset.
  logic [127:0]       data_array [LINES];
  logic [TAG_W-1:0]   tag_array  [LINES];
  logic [LINES-1:0]   valid_reg;
  logic [LINES-1:0]   dirty_reg;
  logic [127:0]       fill_reg;

  // Address fields
  logic [TAG_W-1:0]      tag;
  logic [INDEX_BITS-1:0] index;
  logic [1:0]            word_sel;
  logic [1:0]            byte_sel;

  assign tag      = ADDR[31:4+INDEX_BITS];
  assign index    = ADDR[3+INDEX_BITS:4];
  assign word_sel = ADDR[3:2];
  assign byte_sel = ADDR[1:0];

  // Request decode: a simultaneous load and store is handled as a store.
  logic req, is_store, is_load, hit, idle_hit, store_hit;
  logic [127:0] line;

  assign req       = READ[3] | WRITE[2];
  assign is_store  = WRITE[2];
  assign is_load   = READ[3] & ~WRITE[2];
  assign line      = data_array[index];
  assign hit       = valid_reg[index] && (tag_array[index] == tag);
  assign idle_hit  = (state_reg == S_IDLE) && req && hit;
  assign store_hit = idle_hit && is_store;

  // Load path: select the word, then the byte/half, then extend.
  logic [31:0] load_word;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

  assign load_word = line[{word_sel, 5'b00000} +: 32];
  assign load_byte = load_word[{byte_sel, 3'b000} +: 8];
  assign load_half = ADDR[1] ? load_word[31:16] : load_word[15:0];

  // Size and extend the load result according to funct3
  always_comb begin
    load_ext = '0;
    case (READ[2:0])
      3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_ext = {{16{load_half[15]}}, load_half};
      3'b010:  load_ext = load_word;
      3'b100:  load_ext = {24'b0, load_byte};
      3'b101:  load_ext = {16'b0, load_half};
      default: load_ext = '0;
    endcase
  end

  assign RDATA = (RST && idle_hit && is_load) ? load_ext : 32'b0;

  // Store path: replicate the store data across lanes and build a byte mask.
  logic [31:0]  wdata_rep;
  logic [3:0]   lane_en;
  logic [15:0]  byte_en;
  logic [127:0] merged_line;

  // Replicate store data and pick the byte lanes inside the addressed word
  always_comb begin
    wdata_rep = WDATA;
    lane_en   = 4'b1111;
    case (WRITE[1:0])
      2'b00: begin
        wdata_rep = {4{WDATA[7:0]}};
        lane_en   = 4'b0001 << byte_sel;
      end
      2'b01: begin
        wdata_rep = {2{WDATA[15:0]}};
        lane_en   = ADDR[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_rep = WDATA;
        lane_en   = 4'b1111;
      end
    endcase
  end

  assign byte_en = 16'(lane_en) << {word_sel, 2'b00};

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_merge
      assign merged_line[gi*8 +: 8] = byte_en[gi] ? wdata_rep[(gi % 4)*8 +: 8]
                                                  : line[gi*8 +: 8];
    end
  endgenerate

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  logic busy, mem_read, mem_write;

  // FSM next state and memory handshake outputs
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req && !hit) begin
          busy       = 1'b1;
          state_next = dirty_reg[index] ? S_WRITEBACK : S_FETCH;
        end
      end
      S_WRITEBACK: begin
        busy      = 1'b1;
        mem_write = 1'b1;
        if (!MEM_BUSYWAIT) state_next = S_FETCH;
      end
      S_FETCH: begin
        busy     = 1'b1;
        mem_read = 1'b1;
        if (!MEM_BUSYWAIT) state_next = S_UPDATE;
      end
      S_UPDATE: begin
        busy       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Reset forces the stall low even if the CPU still presents a request.
  assign BUSYWAIT  = busy & RST;
  assign MEM_READ  = mem_read;
  assign MEM_WRITE = mem_write;
  assign MEM_ADDR  = (state_reg == S_WRITEBACK) ? {tag_array[index], index} : {tag, index};
  assign MEM_WDATA = line;

  // Line bookkeeping: store hits, refill capture and line install
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_reg <= '0;
      dirty_reg <= '0;
      fill_reg  <= '0;
    end else begin
      if (store_hit) begin
        data_array[index] <= merged_line;
        dirty_reg[index]  <= 1'b1;
      end
      if (state_reg == S_FETCH && !MEM_BUSYWAIT) begin
        fill_reg <= MEM_RDATA;
      end
      if (state_reg == S_UPDATE) begin
        data_array[index] <= fill_reg;
        tag_array[index]  <= tag;
        valid_reg[index]  <= 1'b1;
        dirty_reg[index]  <= 1'b0;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_reg;
  logic [31:0] miss_count_reg;
  logic        miss_pending_reg;

  // Count first-try hits and IDLE-to-miss transitions; the retry after a
  // refill only clears the pending flag and is not counted as a hit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hit_count_reg    <= '0;
      miss_count_reg   <= '0;
      miss_pending_reg <= 1'b0;
    end else if (state_reg == S_IDLE && req) begin
      if (hit) begin
        if (miss_pending_reg) miss_pending_reg <= 1'b0;
        else                  hit_count_reg    <= hit_count_reg + 32'd1;
      end else begin
        miss_count_reg   <= miss_count_reg + 32'd1;
        miss_pending_reg <= 1'b1;
      end
    end
  end

  assign HIT_COUNT  = hit_count_reg;
  assign MISS_COUNT = miss_count_reg;
`endif

endmodule

// File: tb/tb_dcache_wb_dm.sv
// Self-checking bench for dcache_wb_dm: directed table, multi-cycle corner
// sequences and a randomized run against a block-residency/byte-memory model.
module tb_dcache_wb_dm;
  localparam int IB    = 3;
  localparam int LINES = 1 << IB;

  logic          CLK = 1'b0;
  logic          RST;
  logic [31:0]   ADDR;
  logic [31:0]   WDATA;
  logic [3:0]    READ;
  logic [2:0]    WRITE;
  logic [31:0]   RDATA;
  logic          BUSYWAIT;
  logic          MEM_READ;
  logic          MEM_WRITE;
  logic [27:0]   MEM_ADDR;
  logic [127:0]  MEM_WDATA;
  logic [127:0]  MEM_RDATA = '0;
  logic          MEM_BUSYWAIT = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]   HIT_COUNT;
  logic [31:0]   MISS_COUNT;
`endif

  always #5 CLK = ~CLK;

  dcache_wb_dm #(.INDEX_BITS(IB)) dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .WDATA(WDATA), .READ(READ), .WRITE(WRITE),
    .RDATA(RDATA), .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  // Backing memory (256 blocks = 4 KB) and the CPU-visible byte image.
  logic [127:0] mem_blk [0:255];
  logic [7:0]   arch_mem [0:4095];
  bit           ref_valid [LINES];
  bit           ref_dirty [LINES];
  logic [27:0]  ref_blk   [LINES];
  int           exp_hits = 0, exp_misses = 0;
  int           errors = 0, checks = 0;
  int           mem_lat = 0;
  int           txn = 0;

  function automatic logic [31:0] pat(input int b, input int w);
    return 32'h8000_0000 | 32'(b * 16 + w);
  endfunction

  // Memory responder: busy for mem_lat cycles, then ready for one edge.
  initial begin : memory_model
    int cnt;
    cnt = 0;
    for (int b = 0; b < 256; b++)
      for (int w = 0; w < 4; w++) mem_blk[b][w*32 +: 32] = pat(b, w);
    forever begin
      @(negedge CLK);
      if (MEM_READ || MEM_WRITE) begin
        if (cnt < mem_lat) begin
          MEM_BUSYWAIT = 1'b1;
          cnt++;
        end else begin
          MEM_BUSYWAIT = 1'b0;
          cnt = 0;
          if (MEM_WRITE) mem_blk[MEM_ADDR[7:0]] = MEM_WDATA;
          else           MEM_RDATA = mem_blk[MEM_ADDR[7:0]];
        end
      end else begin
        cnt = 0;
        MEM_BUSYWAIT = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (txn %0d): got %0h expected %0h", name, txn, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      ref_valid[i] = 0;
      ref_dirty[i] = 0;
      ref_blk[i]   = '0;
    end
    for (int i = 0; i < 4096; i++) arch_mem[i] = mem_blk[i / 16][(i % 16)*8 +: 8];
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  function automatic logic [127:0] arch_block(input logic [27:0] b);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = arch_mem[int'(b[7:0]) * 16 + i];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f);
    int ba, ha, wa;
    logic [7:0] b;
    logic [15:0] h;
    logic [31:0] w;
    ba = int'(a[11:0]);
    ha = ba - (ba % 2);
    wa = ba - (ba % 4);
    b = arch_mem[ba];
    h = {arch_mem[ha + 1], arch_mem[ha]};
    w = {arch_mem[wa + 3], arch_mem[wa + 2], arch_mem[wa + 1], arch_mem[wa]};
    case (f)
      3'd0: return {{24{b[7]}}, b};
      3'd1: return {{16{h[15]}}, h};
      3'd2: return w;
      3'd4: return {24'b0, b};
      3'd5: return {16'b0, h};
      default: return 32'b0;
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int ba;
    ba = int'(a[11:0]);
    if (sz == 2'b00) begin
      arch_mem[ba] = d[7:0];
    end else if (sz == 2'b01) begin
      ba = ba - (ba % 2);
      arch_mem[ba] = d[7:0];
      arch_mem[ba + 1] = d[15:8];
    end else begin
      ba = ba - (ba % 4);
      for (int i = 0; i < 4; i++) arch_mem[ba + i] = d[i*8 +: 8];
    end
  endtask

  // One CPU access from presentation to completion, checked against the model.
  task automatic do_access(input logic [31:0] a, input logic [3:0] rd, input logic [2:0] wr,
                           input logic [31:0] wd, input int lat,
                           output logic [31:0] o_rdata, output bit o_miss, output bit o_wb,
                           output logic [27:0] o_wb_addr, output logic [127:0] o_wb_data,
                           output logic [27:0] o_fetch_addr);
    logic [27:0] blk, old_blk, wb_addr, rd_addr;
    logic [127:0] wb_data;
    int idx, busy, fetch_cycles, exp_busy;
    bit exp_hit, exp_wb, is_load, got_wb, got_rd, bad;
    logic [31:0] exp_rd;
    @(negedge CLK);
    txn++;
    mem_lat = lat;
    ADDR = a; WDATA = wd; READ = rd; WRITE = wr;
    #1;
    blk     = a[31:4];
    idx     = int'(a[3+IB:4]);
    old_blk = ref_blk[idx];
    exp_hit = ref_valid[idx] && (ref_blk[idx] == blk);
    exp_wb  = !exp_hit && ref_dirty[idx];
    is_load = rd[3] && !wr[2];
    exp_rd  = is_load ? ref_load(a, rd[2:0]) : 32'b0;
    exp_busy = exp_hit ? 0 : (2 + (lat + 1) + (exp_wb ? lat + 1 : 0));
    busy = 0; fetch_cycles = 0; got_wb = 0; got_rd = 0; bad = 0;
    wb_addr = '0; wb_data = '0; rd_addr = '0;
    while (BUSYWAIT === 1'b1 && busy < 200) begin
      if (RDATA !== 32'b0) bad = 1;
      if (MEM_READ && MEM_WRITE) bad = 1;
      if (MEM_WRITE) begin
        if (got_rd) bad = 1;
        if (!got_wb) begin wb_addr = MEM_ADDR; wb_data = MEM_WDATA; end
        else if (MEM_ADDR !== wb_addr || MEM_WDATA !== wb_data) bad = 1;
        got_wb = 1;
      end
      if (MEM_READ) begin
        if (!got_rd) rd_addr = MEM_ADDR;
        else if (MEM_ADDR !== rd_addr) bad = 1;
        got_rd = 1;
        fetch_cycles++;
      end
      @(negedge CLK);
      #1;
      busy++;
    end
    o_rdata = RDATA; o_miss = (busy > 0); o_wb = got_wb;
    o_wb_addr = wb_addr; o_wb_data = wb_data; o_fetch_addr = rd_addr;
    chk("stall_cycles", busy, exp_busy);
    chk("wb_seen", got_wb, exp_wb);
    if (exp_wb) begin
      chk("wb_addr", wb_addr, old_blk);
      chk("wb_data", wb_data, arch_block(old_blk));
    end
    if (!exp_hit) begin
      chk("fetch_addr", rd_addr, blk);
      chk("fetch_cycles", fetch_cycles, lat + 1);
      chk("stall_protocol", bad, 0);
    end
    chk("rdata", RDATA, exp_rd);
    if (!exp_hit) begin
      ref_valid[idx] = 1; ref_dirty[idx] = 0; ref_blk[idx] = blk;
      exp_misses++;
    end else begin
      exp_hits++;
    end
    if (wr[2]) begin
      ref_store(a, wr[1:0], wd);
      ref_dirty[idx] = 1;
    end
    $display("txn %0d addr=%08h rd=%h wr=%h wd=%08h rdata=%08h stall=%0d wb=%0d",
             txn, a, rd, wr, wd, RDATA, busy, got_wb);
  endtask

  task automatic do_idle();
    @(negedge CLK);
    txn++;
    READ = 4'b0; WRITE = 3'b0;
    #1;
    chk("idle_busywait", BUSYWAIT, 0);
    chk("idle_rdata", RDATA, 0);
    chk("idle_memreq", {MEM_READ, MEM_WRITE}, 0);
`ifdef DCACHE_STATS_EN
    chk("hit_count", HIT_COUNT, exp_hits);
    chk("miss_count", MISS_COUNT, exp_misses);
`endif
    $display("txn %0d idle busywait=%0d rdata=%08h", txn, BUSYWAIT, RDATA);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rd;
    logic [2:0]  wr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_rdata;
    bit          exp_miss;
    bit          exp_wb;
    logic [27:0] exp_fetch;
    logic [27:0] exp_wb_addr;
    logic [31:0] exp_wb_w1;
  } vec_t;

  vec_t tbl [14];

  initial begin : main
    logic [31:0] o_rdata;
    bit o_miss, o_wb;
    logic [27:0] o_wb_addr, o_fetch;
    logic [127:0] o_wb_data;
    int hits0, misses0;
    int f3s [5];

    f3s = '{0, 1, 2, 4, 5};
    tbl[0]  = '{32'h40, 4'b1010, 3'b000, 32'h0,        2, pat(4, 0),    1, 0, 28'h4, 28'h0, 32'h0};
    tbl[1]  = '{32'h44, 4'b0000, 3'b110, 32'hDEADBEEF, 0, 32'h0,        0, 0, 28'h0, 28'h0, 32'h0};
    tbl[2]  = '{32'h47, 4'b1000, 3'b000, 32'h0,        0, 32'hFFFFFFDE, 0, 0, 28'h0, 28'h0, 32'h0};
    tbl[3]  = '{32'h47, 4'b1100, 3'b000, 32'h0,        0, 32'h000000DE, 0, 0, 28'h0, 28'h0, 32'h0};
    tbl[4]  = '{32'h46, 4'b1001, 3'b000, 32'h0,        0, 32'hFFFFDEAD, 0, 0, 28'h0, 28'h0, 32'h0};
    tbl[5]  = '{32'h44, 4'b1001, 3'b000, 32'h0,        0, 32'hFFFFBEEF, 0, 0, 28'h0, 28'h0, 32'h0};
    tbl[6]  = '{32'h45, 4'b1101, 3'b000, 32'h0,        0, 32'h0000BEEF, 0, 0, 28'h0, 28'h0, 32'h0};
    tbl[7]  = '{32'h47, 4'b1010, 3'b000, 32'h0,        0, 32'hDEADBEEF, 0, 0, 28'h0, 28'h0, 32'h0};
    tbl[8]  = '{32'h40, 4'b0000, 3'b100, 32'h1234567F, 0, 32'h0,        0, 0, 28'h0, 28'h0, 32'h0};
    tbl[9]  = '{32'h42, 4'b1010, 3'b101, 32'h0000CAFE, 0, 32'h0,        0, 0, 28'h0, 28'h0, 32'h0};
    tbl[10] = '{32'h40, 4'b1010, 3'b000, 32'h0,        0, 32'hCAFE007F, 0, 0, 28'h0, 28'h0, 32'h0};
    tbl[11] = '{32'hC4, 4'b1010, 3'b000, 32'h0,        1, pat(12, 1),   1, 1, 28'hC, 28'h4, 32'hDEADBEEF};
    tbl[12] = '{32'h44, 4'b1010, 3'b000, 32'h0,        0, 32'hDEADBEEF, 1, 0, 28'h4, 28'h0, 32'h0};
    tbl[13] = '{32'h42, 4'b1000, 3'b000, 32'h0,        0, 32'hFFFFFFFE, 0, 0, 28'h0, 28'h0, 32'h0};

    // Reset with a load already presented: outputs must stay quiet.
    RST = 1'b0; ADDR = 32'h40; WDATA = '0; READ = 4'b1010; WRITE = 3'b000;
    repeat (2) @(negedge CLK);
    #1;
    model_reset();
    chk("reset_busywait", BUSYWAIT, 0);
    chk("reset_memreq", {MEM_READ, MEM_WRITE}, 0);
    chk("reset_rdata", RDATA, 0);
`ifdef DCACHE_STATS_EN
    chk("reset_hit_count", HIT_COUNT, 0);
    chk("reset_miss_count", MISS_COUNT, 0);
`endif
    READ = 4'b0;
    @(negedge CLK);
    RST = 1'b1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      do_access(tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].wdata, tbl[i].lat,
                o_rdata, o_miss, o_wb, o_wb_addr, o_wb_data, o_fetch);
      chk("tbl_rdata", o_rdata, tbl[i].exp_rdata);
      chk("tbl_miss", o_miss, tbl[i].exp_miss);
      chk("tbl_wb", o_wb, tbl[i].exp_wb);
      if (tbl[i].exp_wb) begin
        chk("tbl_wb_addr", o_wb_addr, tbl[i].exp_wb_addr);
        chk("tbl_wb_word1", o_wb_data[63:32], tbl[i].exp_wb_w1);
      end
      if (tbl[i].exp_miss) chk("tbl_fetch_addr", o_fetch, tbl[i].exp_fetch);
    end
    do_idle();

    // Slow memory: five busy cycles during the refill.
    do_access(32'h100, 4'b1010, 3'b000, 32'h0, 5, o_rdata, o_miss, o_wb, o_wb_addr, o_wb_data, o_fetch);
    chk("slow_miss", o_miss, 1);
    chk("slow_rdata", o_rdata, pat(16, 0));

    // Reset in the middle of a refill abandons it; the retry misses again.
    @(negedge CLK);
    txn++;
    mem_lat = 5;
    ADDR = 32'h500; READ = 4'b1010; WRITE = 3'b000;
    repeat (3) @(negedge CLK);
    #1;
    chk("midfetch_memread", MEM_READ, 1);
    RST = 1'b0;
    #1;
    chk("midfetch_rst_memread", MEM_READ, 0);
    chk("midfetch_rst_busywait", BUSYWAIT, 0);
    chk("midfetch_rst_rdata", RDATA, 0);
    READ = 4'b0;
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
    do_access(32'h500, 4'b1010, 3'b000, 32'h0, 1, o_rdata, o_miss, o_wb, o_wb_addr, o_wb_data, o_fetch);
    chk("rst_remiss", o_miss, 1);
    chk("rst_remiss_rdata", o_rdata, pat(80, 0));

    // Counter sequence: miss, hit, hit, miss.
    hits0 = exp_hits;
    misses0 = exp_misses;
    do_access(32'h200, 4'b1010, 3'b000, 32'h0, 1, o_rdata, o_miss, o_wb, o_wb_addr, o_wb_data, o_fetch);
    do_access(32'h204, 4'b1010, 3'b000, 32'h0, 1, o_rdata, o_miss, o_wb, o_wb_addr, o_wb_data, o_fetch);
    do_access(32'h208, 4'b0000, 3'b110, 32'h55AA55AA, 1, o_rdata, o_miss, o_wb, o_wb_addr, o_wb_data, o_fetch);
    do_access(32'h300, 4'b1010, 3'b000, 32'h0, 1, o_rdata, o_miss, o_wb, o_wb_addr, o_wb_data, o_fetch);
    chk("seq_dirty_evict", o_wb, 1);
    do_idle();
`ifdef DCACHE_STATS_EN
    chk("seq_hit_count", HIT_COUNT, hits0 + 2);
    chk("seq_miss_count", MISS_COUNT, misses0 + 2);
`endif

    // Randomized traffic over a small block set to mix hits, misses and evictions.
    for (int n = 0; n < 300; n++) begin
      int blk, off, op, lat;
      logic [3:0] rd;
      logic [2:0] wr;
      blk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 31));
      off = int'($urandom_range(0, 15));
      op  = int'($urandom_range(0, 9));
      lat = int'($urandom_range(0, 3));
      rd = 4'b0;
      wr = 3'b0;
      if (op == 0) begin
        do_idle();
      end else begin
        if (op <= 4 || op == 9) rd = {1'b1, 3'(f3s[$urandom_range(0, 4)])};
        if (op >= 5) wr = {1'b1, 2'($urandom_range(0, 2))};
        do_access(32'(blk * 16 + off), rd, wr, $urandom, lat,
                  o_rdata, o_miss, o_wb, o_wb_addr, o_wb_data, o_fetch);
      end
    end
    do_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
